// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package nibble_serial_add_ctrl_pkg;

  localparam int NIB_W = 4;

  // 2'd3 is unused; the FSM treats it as a fault and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operand width must split evenly into whole nibbles.
  function automatic bit width_ok(input int w);
    return (w % NIB_W == 0) && (w >= NIB_W);
  endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand-in / sum-out handshake bundle for the nibble-serial adder.
interface nibble_serial_add_ctrl_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, busy
  );
endinterface

// File: rtl/nibble_serial_add_ctrl_adder4.sv
// Combinational 4-bit ripple-carry slice shared across all nibbles.
module nibble_adder4
  import nibble_serial_add_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] x,
  input  logic [NIB_W-1:0] y,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co
);
  logic [NIB_W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
  end

  assign co = c[NIB_W];
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide adder built from one 4-bit slice reused over WIDTH/4 cycles,
// LS nibble first, carry held in a register between nibbles.
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  nibble_serial_add_ctrl_if.slave bus
);
  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("nibble_serial_add_ctrl: WIDTH must be a positive multiple of 4");
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] nib_cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH:0]   sum_r;
  logic [NIB_W-1:0] s4;
  logic             co;
  logic             last;

  assign last = (nib_cnt == LAST);

  nibble_adder4 u_slice (
    .x  (a_sh[NIB_W-1:0]),
    .y  (b_sh[NIB_W-1:0]),
    .ci (carry),
    .s  (s4),
    .co (co)
  );

  // All handshake outputs decode registered state only, so there is no
  // combinational path from in_valid or out_ready.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == RUN) || (state == DONE);
  assign bus.sum       = sum_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; the unused encoding falls back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, then one nibble per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nib_cnt <= '0;
      carry   <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_r   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_sh    <= bus.a;
          b_sh    <= bus.b;
          carry   <= bus.cin;
          sum_r   <= '0;
          nib_cnt <= '0;
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++)
            if (nib_cnt == CNT_W'(i)) sum_r[i*NIB_W +: NIB_W] <= s4;
          carry <= co;
          a_sh  <= a_sh >> NIB_W;
          b_sh  <= b_sh >> NIB_W;
          if (last) sum_r[WIDTH] <= co;
          else      nib_cnt      <= nib_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench: vector table, hand-written corner sequences and a
// randomized phase scored against plain a+b+cin arithmetic.
module tb_nibble_serial_add_ctrl;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic bp_en = 1'b0;
  logic bp_val = 1'b1;
  logic or_man = 1'b1;
  logic mon_en = 1'b0;
  logic [W:0] exp_q[$];

  nibble_serial_add_ctrl_if #(.WIDTH(W)) bus ();

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.out_ready = bp_en ? bp_val : or_man;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W:0]   exp;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  // Presents operands and returns just after the accepting rising edge.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, output int acc_cyc);
    bit ok;
    ok = 0;
    acc_cyc = -1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = ta;
    bus.b = tb_;
    bus.cin = tc;
    for (int i = 0; i < 200; i++) begin
      if (bus.in_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end else begin
      acc_cyc = cyc;
      if (mon_en) exp_q.push_back(ref_sum(ta, tb_, tc));
    end
    @(posedge clk);
  endtask

  // Called on the falling edge after the accept edge; counts cycles to out_valid.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Scoreboard for the streaming phases.
  always @(negedge clk) begin
    if (mon_en && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream_extra: got sum=%0h expected no output", bus.sum);
      end else begin
        check("stream_sum", 64'(bus.sum), 64'(exp_q.pop_front()));
      end
    end
  end

  // Random backpressure source, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      bp_val = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    vec_t tbl[5];
    int lat, acc0, acc1;
    logic [W-1:0] ra, rb;
    logic rc;

    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 17'h05555};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 17'h10000};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF};
    tbl[3] = '{16'h0000, 16'h0000, 1'b1, 17'h00001};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 17'h10000};

    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sum", 64'(bus.sum), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);

    // Vector table, out_ready held high
    for (int t = 0; t < 5; t++) begin
      start_op(tbl[t].a, tbl[t].b, tbl[t].cin, acc0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      bus.cin = 1'($urandom);
      check("tbl_busy_run", 64'(bus.busy), 64'd1);
      wait_done(lat);
      check("tbl_latency", 64'(lat), 64'd4);
      check("tbl_sum", 64'(bus.sum), 64'(tbl[t].exp));
      check("tbl_in_ready_done", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      check("tbl_pulse_1cyc", 64'(bus.out_valid), 64'd0);
      check("tbl_idle_ready", 64'(bus.in_ready), 64'd1);
    end

    // Carry register stays set through every nibble of FFFF+FFFF+1
    start_op(16'hFFFF, 16'hFFFF, 1'b1, acc0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("carry_after_accept", 64'(dut.carry), 64'd1);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("carry_after_run", 64'(dut.carry), 64'd1);
    end
    check("carry_sum", 64'(bus.sum), 64'h1FFFF);
    @(negedge clk);

    // Backpressure with a competing request held on the inputs
    or_man = 1'b0;
    start_op(16'h1234, 16'h4321, 1'b0, acc0);
    @(negedge clk);
    bus.a = 16'h00AA;
    bus.b = 16'h0055;
    bus.cin = 1'b1;
    wait_done(lat);
    check("bp_latency", 64'(lat), 64'd4);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_sum_stable", 64'(bus.sum), 64'h05555);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    or_man = 1'b1;
    @(negedge clk);
    check("bp_bubble_valid", 64'(bus.out_valid), 64'd0);
    check("bp_bubble_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_second_busy", 64'(bus.busy), 64'd1);
    wait_done(lat);
    check("bp_second_latency", 64'(lat), 64'd4);
    check("bp_second_sum", 64'(bus.sum), 64'h00100);
    @(negedge clk);

    // Reset two cycles into RUN
    start_op(16'hABCD, 16'h1111, 1'b1, acc0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_sum", 64'(bus.sum), 64'd0);
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    start_op(16'h0F0F, 16'h00F1, 1'b0, acc0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_done(lat);
    check("abort_next_latency", 64'(lat), 64'd4);
    check("abort_next_sum", 64'(bus.sum), 64'h01000);
    @(negedge clk);

    // Throughput: in_valid and out_ready held high
    mon_en = 1'b1;
    acc1 = -1;
    for (int k = 0; k < 3; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      start_op(ra, rb, rc, acc0);
      if (k > 0) check("tput_interval", 64'(acc0 - acc1), 64'd6);
      acc1 = acc0;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);

    // Random operands with random backpressure
    bp_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      start_op(ra, rb, rc, acc0);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_drain: got %0d pending expected 0", exp_q.size());
    end
    bp_en = 1'b0;
    mon_en = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
